// File: rtl/vu_frame_controller_if.sv
// Level-sample handshake between the audio front end and the VU frame controller.
interface vu_frame_controller_if;
  logic       lvl_valid;
  logic [7:0] lvl_left;
  logic [7:0] lvl_right;
  logic       lvl_ready;

  modport master (
    output lvl_valid,
    output lvl_left,
    output lvl_right,
    input  lvl_ready
  );

  modport slave (
    input  lvl_valid,
    input  lvl_left,
    input  lvl_right,
    output lvl_ready
  );
endinterface

// File: rtl/vu_frame_controller.sv
// Two-channel VU-meter renderer: buffers level samples, commits them to bars and
// peak-hold markers only in vertical blanking, and paints registered RGB 3/3/2.
module vu_frame_controller #(
  parameter int C_SIZE    = 9,
  parameter int THADDR    = 640,
  parameter int TVADDR    = 480,
  parameter int PEAK_HOLD = 30,
  parameter int DECAY     = 4
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic [C_SIZE:0]       h_count,
  input  logic [C_SIZE:0]       v_count,
  vu_frame_controller_if.slave  lvl,
  output logic [2:0]            red,
  output logic [2:0]            green,
  output logic [1:0]            blue,
  output logic                  frame_tick
);

  localparam int CW = C_SIZE + 1;
  localparam int AW = (CW > 10) ? CW + 1 : 11;

  localparam logic [C_SIZE:0] H_END   = CW'(THADDR);
  localparam logic [C_SIZE:0] V_END   = CW'(TVADDR);
  localparam logic [C_SIZE:0] L_FIRST = CW'(64);
  localparam logic [C_SIZE:0] L_LAST  = CW'(287);
  localparam logic [C_SIZE:0] R_FIRST = CW'(352);
  localparam logic [C_SIZE:0] R_LAST  = CW'(575);
  localparam logic [C_SIZE:0] RED_END = CW'(96);
  localparam logic [C_SIZE:0] YEL_END = CW'(192);
  localparam logic [AW-1:0]   V_END_W = AW'(TVADDR);
  localparam logic [5:0]      HOLD_INIT  = 6'(PEAK_HOLD);
  localparam logic [9:0]      DECAY_STEP = 10'(DECAY);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    ACTIVE = 2'd1,
    UPD_L  = 2'd2,
    UPD_R  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0] pending_l;
  logic [7:0] pending_r;
  logic [9:0] bar_l;
  logic [9:0] bar_r;
  logic [9:0] peak_l;
  logic [9:0] peak_r;
  logic [5:0] hold_l;
  logic [5:0] hold_r;
  logic       ready_q;

  logic       at_trigger;
  logic       at_top;
  logic       accept;

  // Level * 15/8 built from truncated shifts; 255 maps to 476, always below TVADDR.
  function automatic logic [9:0] scale(input logic [7:0] level);
    logic [9:0] l10;
    l10 = {2'b00, level};
    return l10 + (l10 >> 1) + (l10 >> 2) + (l10 >> 3);
  endfunction

  assign at_trigger    = (v_count == V_END) && (h_count == '0);
  assign at_top        = (v_count == '0) && (h_count == '0);
  assign accept        = lvl.lvl_valid && ready_q;
  assign lvl.lvl_ready = ready_q;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state <= BLANK;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ACTIVE:  if (at_trigger) next_state = UPD_L;
      UPD_L:   next_state = UPD_R;
      UPD_R:   next_state = BLANK;
      BLANK: begin
        if (at_trigger) begin
          next_state = UPD_L;
        end else if (at_top) begin
          next_state = ACTIVE;
        end
      end
      default: next_state = BLANK;
    endcase
  end

  // Ready and the tick are registered off next_state so they line up with the state register.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      ready_q    <= (next_state == ACTIVE) || (next_state == BLANK);
      frame_tick <= (next_state == UPD_L) && (state != UPD_L);
    end
  end

  logic [7:0] commit_level;
  logic [9:0] commit_scaled;
  logic [9:0] cur_peak;
  logic [9:0] new_peak;
  logic [9:0] decayed;
  logic [5:0] cur_hold;
  logic [5:0] new_hold;

  // One shared commit datapath; UPD_L and UPD_R each steer a channel through it.
  always_comb begin
    commit_level  = (state == UPD_R) ? pending_r : pending_l;
    cur_peak      = (state == UPD_R) ? peak_r : peak_l;
    cur_hold      = (state == UPD_R) ? hold_r : hold_l;
    commit_scaled = scale(commit_level);
    decayed       = (cur_peak >= DECAY_STEP) ? (cur_peak - DECAY_STEP) : '0;
    new_peak      = cur_peak;
    new_hold      = cur_hold;
    if (commit_scaled > cur_peak) begin
      new_peak = commit_scaled;
      new_hold = HOLD_INIT;
    end else if (cur_hold != '0) begin
      new_hold = cur_hold - 6'd1;
    end else begin
      new_peak = (decayed > commit_scaled) ? decayed : commit_scaled;
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      pending_l <= '0;
      pending_r <= '0;
      bar_l     <= '0;
      bar_r     <= '0;
      peak_l    <= '0;
      peak_r    <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (accept) begin
        pending_l <= lvl.lvl_left;
        pending_r <= lvl.lvl_right;
      end
      if (state == UPD_L) begin
        bar_l  <= commit_scaled;
        peak_l <= new_peak;
        hold_l <= new_hold;
      end
      if (state == UPD_R) begin
        bar_r  <= commit_scaled;
        peak_r <= new_peak;
        hold_r <= new_hold;
      end
    end
  end

  logic          in_display;
  logic          in_left;
  logic          in_right;
  logic [9:0]    sel_bar;
  logic [9:0]    sel_peak;
  logic [AW-1:0] v_wide;
  logic [AW-1:0] bar_top;
  logic [AW-1:0] peak_top;
  logic          lit;
  logic          marker;
  logic [7:0]    pixel;

  // Bars grow upward from the bottom line; the 4-row peak marker wins over the bar.
  always_comb begin
    in_display = (h_count < H_END) && (v_count < V_END);
    in_left    = (h_count >= L_FIRST) && (h_count <= L_LAST);
    in_right   = (h_count >= R_FIRST) && (h_count <= R_LAST);
    sel_bar    = in_right ? bar_r : bar_l;
    sel_peak   = in_right ? peak_r : peak_l;
    v_wide     = AW'(v_count);
    bar_top    = V_END_W - AW'(sel_bar);
    peak_top   = V_END_W - AW'(sel_peak);
    lit        = (v_wide >= bar_top);
    marker     = (sel_peak != '0) && (v_wide >= peak_top) && (v_wide <= peak_top + AW'(3));
    pixel      = 8'h00;
    if (in_display && (in_left || in_right)) begin
      if (marker) begin
        pixel = 8'b111_111_11;
      end else if (lit) begin
        if (v_count < RED_END) begin
          pixel = 8'b111_000_00;
        end else if (v_count < YEL_END) begin
          pixel = 8'b111_111_00;
        end else begin
          pixel = 8'b000_111_00;
        end
      end
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pixel[7:5];
      green <= pixel[4:2];
      blue  <= pixel[1:0];
    end
  end

endmodule

// File: doc/vu_frame_controller.md
Name: vu_frame_controller

Overview:
- Frame-synchronous renderer and scheduler for the two-channel VU-meter display.
- Accepts left/right audio level samples at any time and commits them to the displayed bars only during vertical blanking, so bars never tear mid-frame.
- Maintains a per-channel peak-hold marker with timed decay.
- Drives registered RGB (3/3/2) from the horizontal/vertical pixel counts produced by the VGA timing generator.

Parameters:
- C_SIZE, 9, counter MSB index; count ports are C_SIZE+1 bits wide.
- THADDR, 640, horizontal addressable pixels.
- TVADDR, 480, vertical addressable lines.
- PEAK_HOLD, 30, frames a new peak is held before decay (max 63).
- DECAY, 4, scaled-height units the peak falls per frame after hold expires.

Ports:
- pixel_clock  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- h_count  in  C_SIZE+1  current horizontal pixel count from the timing generator.
- v_count  in  C_SIZE+1  current vertical line count from the timing generator.
- lvl_valid  in  1  level sample offered.
- lvl_left  in  8  left-channel level, unsigned.
- lvl_right  in  8  right-channel level, unsigned.
- lvl_ready  out  1  controller can accept a sample.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.
- frame_tick  out  1  one-cycle pulse when a frame commit begins.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs red/green/blue, lvl_ready and frame_tick = 0.
  - State = BLANK.
  - Pending, bar, peak and hold registers = 0.
- Handshake:
  - A sample is accepted on a rising edge where lvl_valid && lvl_ready.
  - Accepted samples write pending_l/pending_r; the latest accepted sample wins and older ones are overwritten.
  - lvl_ready is registered: 1 in ACTIVE and BLANK, 0 in UPD_L and UPD_R. It first rises one cycle after reset deasserts.
- Scaling:
  - scaled = L + (L>>1) + (L>>2) + (L>>3), computed at 10 bits.
  - Maximum is 476 for L = 255, so scaled is always < TVADDR.
- State machine:
  - ACTIVE: v_count < TVADDR. Move to UPD_L when v_count == TVADDR and h_count == 0.
  - UPD_L: commits the left channel. Always moves to UPD_R next cycle.
  - UPD_R: commits the right channel. Always moves to BLANK next cycle.
  - BLANK: remains until v_count == 0 and h_count == 0, then moves to ACTIVE.
  - From reset, BLANK also moves to UPD_L when v_count == TVADDR and h_count == 0.
- Sample accepted on the trigger edge: it lands in pending before UPD_L, so it is included in that frame's commit.
- Commit (per channel, in UPD_L / UPD_R):
  - bar = scaled(pending).
  - If scaled > peak: peak = scaled, hold = PEAK_HOLD.
  - Else if hold != 0: hold = hold - 1.
  - Else: peak = max(peak - DECAY, scaled), saturating at 0.
- frame_tick: registered pulse, high for exactly the first cycle the state is UPD_L.
- Rendering:
  - Outputs are registered, with 1-cycle latency from h_count/v_count.
  - Inside the display area (h < THADDR, v < TVADDR):
    - Left bar columns are 64..287; right bar columns are 352..575.
    - Peak marker: rows TVADDR-peak .. TVADDR-peak+3 inside a bar column are white (111,111,11). The marker overrides the bar and is drawn only when peak != 0.
    - Bar: a pixel is lit when v >= TVADDR - bar.
    - Lit pixel colour by row: v < 96 red (111,000,00); 96 <= v < 192 yellow (111,111,00); otherwise green (000,111,00).
    - All other display pixels are black.
  - Outside the display area: black.
- Rendering always uses committed bar/peak values; pending values never affect pixels.
- Reset mid-frame: everything returns to reset values immediately. The display is black until the next commit; that commit is the first v_count == TVADDR, h_count == 0 after reset deasserts.

Test Plan:
- Reset release with counters sweeping -> all RGB outputs 0 until the first commit; lvl_ready=1 one cycle after release; frame_tick single pulse at the UPD_L entry.
- Accept L=128, R=0, then commit -> left bar = 240; pixel (100,300) green (000,111,00); (100,239) black; right column pixel (400,470) black.
- Offer three samples L=10, 200, 255 before the commit -> the commit uses 255; bar = 476; (100,50) red; (100,150) yellow; (100,4..7) white peak marker.
- After L=255, commit L=0 every frame -> peak stays 476 for 30 commits; 31st commit peak=472, 32nd 468; bar = 0.
- lvl_valid held high across the trigger edge and the UPD states -> lvl_ready=0 for exactly 2 cycles; the sample presented on the trigger edge is committed that frame.
- Assert reset at v_count=200 with bars non-zero -> RGB=0 immediately; display stays black until the next commit; peak and hold are cleared.
